// File: rtl/rtap_bist_master_if.sv
// Request/response handshake between a JTAG-side client and rtap_bist_master.
`ifndef JTAG_DATA_REQ_WIDTH
`define JTAG_DATA_REQ_WIDTH 192
`endif
`ifndef JTAG_DATA_RES_WIDTH
`define JTAG_DATA_RES_WIDTH 256
`endif

interface rtap_bist_master_if;
  logic                            req_val;
  logic                            req_rdy;
  logic                            req_wr;
  logic [7:0]                      req_id;
  logic [7:0]                      req_bsel;
  logic [15:0]                     req_addr;
  logic [`JTAG_DATA_REQ_WIDTH-1:0] req_wdata;
  logic                            res_val;
  logic                            res_rdy;
  logic [`JTAG_DATA_RES_WIDTH-1:0] res_rdata;

  modport master (
    output req_val, req_wr, req_id, req_bsel, req_addr, req_wdata, res_rdy,
    input  req_rdy, res_val, res_rdata
  );

  modport slave (
    input  req_val, req_wr, req_id, req_bsel, req_addr, req_wdata, res_rdy,
    output req_rdy, res_val, res_rdata
  );
endinterface

// File: rtl/rtap_bist_master.sv
// Serialises one SRAM BIST read/write transaction per request onto the 4-bit
// wrapper bus and returns the read nibbles as a 256-bit response.
//
// state | meaning
// IDLE  | ready for a request, bus NOP
// ID    | shift target SRAM ID, 2 nibbles
// BSEL  | shift bit-select, 2 nibbles
// ADDR  | shift address, 4 nibbles
// OP    | read opcode, or first write-data nibble
// RWAIT | NOP while the wrapper fetches the read word
// RDATA | 64 SHIFT_DATA cycles sampling srams_rtap_data
// WDATA | remaining 47 write-data nibbles
// GAP   | POST_GAP NOP cycles, response valid from the first one
// RESP  | gap done, waiting for the response to be consumed
`ifndef JTAG_DATA_REQ_WIDTH
`define JTAG_DATA_REQ_WIDTH 192
`endif
`ifndef JTAG_DATA_RES_WIDTH
`define JTAG_DATA_RES_WIDTH 256
`endif
`ifndef BIST_OP_WIDTH
`define BIST_OP_WIDTH 4
`endif
`ifndef SRAM_WRAPPER_BUS_WIDTH
`define SRAM_WRAPPER_BUS_WIDTH 4
`endif

module rtap_bist_master #(
  parameter int unsigned POST_GAP = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  rtap_bist_master_if.slave                  bus,
  output logic [`BIST_OP_WIDTH-1:0]          rtap_srams_bist_command,
  output logic [`SRAM_WRAPPER_BUS_WIDTH-1:0] rtap_srams_bist_data,
  input  logic [`SRAM_WRAPPER_BUS_WIDTH-1:0] srams_rtap_data
);

  localparam int WW = `JTAG_DATA_REQ_WIDTH;
  localparam int RW = `JTAG_DATA_RES_WIDTH;
  localparam int BW = `SRAM_WRAPPER_BUS_WIDTH;
  localparam int OW = `BIST_OP_WIDTH;

  localparam logic [OW-1:0] OP_NOP           = OW'(0);
  localparam logic [OW-1:0] OP_READ          = OW'(1);
  localparam logic [OW-1:0] OP_SHIFT_ID      = OW'(2);
  localparam logic [OW-1:0] OP_SHIFT_BSEL    = OW'(3);
  localparam logic [OW-1:0] OP_SHIFT_ADDRESS = OW'(4);
  localparam logic [OW-1:0] OP_SHIFT_DATA    = OW'(5);

  localparam logic [6:0] RDATA_LAST = 7'(RW / BW - 1);
  localparam logic [6:0] WDATA_LAST = 7'(WW / BW - 2);
  localparam logic [6:0] GAP_LAST   = 7'(POST_GAP - 1);

  typedef enum logic [3:0] {
    IDLE, ID, BSEL, ADDR, OP, RWAIT, RDATA, WDATA, GAP, RESP
  } state_t;

  state_t          state, state_n;
  logic [6:0]      cnt, cnt_n;
  logic [OW-1:0]   cmd_n;
  logic [BW-1:0]   data_n;
  logic [7:0]      id_src;

  logic            wr_q;
  logic [7:0]      id_q;
  logic [7:0]      bsel_q;
  logic [15:0]     addr_q;
  logic [WW-1:0]   wdata_q;
  logic            res_val_q;
  logic [RW-1:0]   rdata_q;

  logic            accept;

  assign accept      = (state == IDLE) && bus.req_val;
  assign bus.req_rdy = (state == IDLE);
  assign bus.res_val = res_val_q;
  assign bus.res_rdata = rdata_q;

  // The first ID nibble leaves on the acceptance edge, before id_q holds it.
  assign id_src = (state == IDLE) ? bus.req_id : id_q;

  always_comb begin
    state_n = state;
    cnt_n   = '0;
    cmd_n   = OP_NOP;
    data_n  = '0;

    case (state)
      IDLE:    if (bus.req_val) state_n = ID;
      ID:      if (cnt == 7'd1) state_n = BSEL;
      BSEL:    if (cnt == 7'd1) state_n = ADDR;
      ADDR:    if (cnt == 7'd3) state_n = OP;
      OP:      state_n = wr_q ? WDATA : RWAIT;
      RWAIT:   state_n = RDATA;
      RDATA:   if (cnt == RDATA_LAST) state_n = GAP;
      WDATA:   if (cnt == WDATA_LAST) state_n = GAP;
      GAP:     if (cnt == GAP_LAST) state_n = (res_val_q && !bus.res_rdy) ? RESP : IDLE;
      RESP:    if (bus.res_rdy) state_n = IDLE;
      default: state_n = IDLE;
    endcase

    if (state_n != state)                      cnt_n = '0;
    else if (state == IDLE || state == RESP)   cnt_n = cnt;
    else                                       cnt_n = cnt + 7'd1;

    // Bus outputs are registered, so they are decoded from the next state.
    case (state_n)
      ID: begin
        cmd_n  = OP_SHIFT_ID;
        data_n = cnt_n[0] ? id_src[3:0] : id_src[7:4];
      end
      BSEL: begin
        cmd_n  = OP_SHIFT_BSEL;
        data_n = cnt_n[0] ? bsel_q[3:0] : bsel_q[7:4];
      end
      ADDR: begin
        cmd_n = OP_SHIFT_ADDRESS;
        case (cnt_n[1:0])
          2'd0:    data_n = addr_q[15:12];
          2'd1:    data_n = addr_q[11:8];
          2'd2:    data_n = addr_q[7:4];
          default: data_n = addr_q[3:0];
        endcase
      end
      OP: begin
        cmd_n  = wr_q ? OP_SHIFT_DATA : OP_READ;
        data_n = wr_q ? wdata_q[WW-1 -: BW] : '0;
      end
      WDATA: begin
        cmd_n  = OP_SHIFT_DATA;
        data_n = wdata_q[WW-BW-1 -: BW];
      end
      RDATA:   cmd_n = OP_SHIFT_DATA;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                   <= IDLE;
      cnt                     <= '0;
      rtap_srams_bist_command <= OP_NOP;
      rtap_srams_bist_data    <= '0;
    end else begin
      state                   <= state_n;
      cnt                     <= cnt_n;
      rtap_srams_bist_command <= cmd_n;
      rtap_srams_bist_data    <= data_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q      <= 1'b0;
      id_q      <= '0;
      bsel_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      res_val_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      if (accept) begin
        wr_q    <= bus.req_wr;
        id_q    <= bus.req_id;
        bsel_q  <= bus.req_bsel;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        rdata_q <= '0;
      end
      // Left-shift so the next write nibble is always just below the top one.
      if (state_n == WDATA) wdata_q <= {wdata_q[WW-BW-1:0], {BW{1'b0}}};
      if (state == RDATA)   rdata_q <= {rdata_q[RW-BW-1:0], srams_rtap_data};
      if ((state == RDATA || state == WDATA) && state_n == GAP)
        res_val_q <= 1'b1;
      else if (res_val_q && bus.res_rdy)
        res_val_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rtap_bist_master.sv
// Randomised bench for rtap_bist_master: a per-cycle bus scoreboard, an SRAM
// wrapper model on the nibble bus and a reference memory for read data.
module tb_rtap_bist_master;
  localparam int PG = 2;
  localparam logic [3:0] C_NOP = 4'h0, C_READ = 4'h1, C_ID = 4'h2,
                         C_BSEL = 4'h3, C_ADDR = 4'h4, C_DATA = 4'h5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rtap_bist_master_if bus();
  logic [3:0] cmd, bdata, sdata;

  rtap_bist_master #(.POST_GAP(PG)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .rtap_srams_bist_command(cmd),
    .rtap_srams_bist_data(bdata),
    .srams_rtap_data(sdata)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic bit has_wrapper(input logic [7:0] id);
    return (id == 8'h25) || (id == 8'h26) || (id == 8'h3A);
  endfunction

  logic [255:0] ref_mem [logic [23:0]];
  logic [255:0] w_mem   [logic [23:0]];

  // SRAM wrapper model: decodes the bist bus and serves/commits words.
  logic [7:0]   w_id = 8'h0;
  logic [15:0]  w_addr = 16'h0;
  logic         w_rd = 1'b0;
  logic [6:0]   w_k = 7'd0;
  logic [6:0]   w_wcnt = 7'd0;
  logic [191:0] w_wsh = '0;
  logic [255:0] w_rword = '0;
  logic [255:0] w_tmp;

  always @(posedge clk) begin
    case (cmd)
      C_ID: begin
        w_id   <= {w_id[3:0], bdata};
        w_rd   <= 1'b0;
        w_wcnt <= 7'd0;
      end
      C_ADDR: w_addr <= {w_addr[11:0], bdata};
      C_READ: begin
        w_rd    <= 1'b1;
        w_k     <= 7'd0;
        w_rword <= w_mem.exists({w_id, w_addr}) ? w_mem[{w_id, w_addr}] : '0;
      end
      C_DATA: begin
        if (w_rd) w_k <= w_k + 7'd1;
        else begin
          w_wsh  <= {w_wsh[187:0], bdata};
          w_wcnt <= w_wcnt + 7'd1;
        end
      end
      C_NOP: begin
        if (!w_rd && w_wcnt == 7'd48 && has_wrapper(w_id)) w_mem[{w_id, w_addr}] = {64'b0, w_wsh};
        w_wcnt <= 7'd0;
      end
      default: ;
    endcase
  end

  always_comb begin
    sdata = 4'h0;
    w_tmp = '0;
    if (w_rd && cmd == C_DATA && has_wrapper(w_id)) begin
      w_tmp = w_rword >> (4 * (63 - int'(w_k)));
      sdata = w_tmp[3:0];
    end
  end

  // Expected bus per cycle; an empty queue means NOP.
  logic [7:0] exp_q[$];
  logic [7:0] trace [128];
  int gcyc = 0, tcyc = 0, last_sd = 0, id_gap = -1;
  logic [3:0] prev_cmd = 4'h0;

  always @(negedge clk) begin
    logic [7:0] e;
    gcyc++;
    tcyc++;
    if (tcyc < 128) trace[tcyc] = {cmd, bdata};
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    check("bus", {cmd, bdata}, e);
    if (cmd == C_DATA) last_sd = gcyc;
    if (cmd == C_ID && prev_cmd != C_ID) id_gap = gcyc - last_sd - 1;
    prev_cmd = cmd;
  end

  // Called just after a falling edge; returns just after a falling edge.
  task automatic send(input bit wr, input logic [7:0] id, input logic [7:0] bsel,
                      input logic [15:0] addr, input logic [191:0] wdata,
                      input int hold, input int abort_cyc, input bit first_edge,
                      output int res_cyc, output logic [255:0] res_data);
    logic [255:0] exp_rd;
    logic [3:0] nib;
    int waits, cyc, h, idle, gap_last;
    bit rdy;
    waits = 0; cyc = 0; res_cyc = -1; res_data = '0;
    bus.req_val = 1'b1; bus.req_wr = wr; bus.req_id = id; bus.req_bsel = bsel;
    bus.req_addr = addr; bus.req_wdata = wdata; bus.res_rdy = (hold == 0);
    rdy = bus.req_rdy;
    while (!rdy && waits < 200) begin
      @(negedge clk); waits++; rdy = bus.req_rdy;
    end
    if (!rdy) begin
      check("accept_timeout", 0, 1);
      bus.req_val = 1'b0;
      return;
    end
    @(posedge clk); #1;
    tcyc = 0;
    if (first_edge) check("accept_first_edge", waits, 0);
    bus.req_val = 1'b0; bus.req_wr = $urandom_range(0, 1); bus.req_id = 8'($urandom);
    bus.req_bsel = 8'($urandom); bus.req_addr = 16'($urandom);
    bus.req_wdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};

    exp_q.push_back({C_ID, id[7:4]});     exp_q.push_back({C_ID, id[3:0]});
    exp_q.push_back({C_BSEL, bsel[7:4]}); exp_q.push_back({C_BSEL, bsel[3:0]});
    for (int i = 0; i < 4; i++) begin
      nib = 4'(addr >> (4 * (3 - i)));
      exp_q.push_back({C_ADDR, nib});
    end
    if (wr) begin
      for (int i = 0; i < 48; i++) begin
        nib = 4'(wdata >> (4 * (47 - i)));
        exp_q.push_back({C_DATA, nib});
      end
      exp_rd = '0;
      if (has_wrapper(id)) ref_mem[{id, addr}] = {64'b0, wdata};
    end else begin
      exp_q.push_back({C_READ, 4'h0});
      exp_q.push_back({C_NOP, 4'h0});
      for (int i = 0; i < 64; i++) exp_q.push_back({C_DATA, 4'h0});
      exp_rd = (has_wrapper(id) && ref_mem.exists({id, addr})) ? ref_mem[{id, addr}] : '0;
    end
    gap_last = (wr ? 56 : 74) + PG;

    while (cyc < 200) begin
      @(negedge clk); cyc++;
      if (abort_cyc != 0 && cyc == abort_cyc) begin
        #1 rst = 1'b1; exp_q.delete(); #1;
        check("rst_bus", {cmd, bdata}, 8'h00);
        check("rst_req_rdy", bus.req_rdy, 1);
        check("rst_res_val", bus.res_val, 0);
        check("rst_rdata", bus.res_rdata, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        bus.res_rdy = 1'b0;
        return;
      end
      if (bus.res_val) break;
    end
    if (!bus.res_val) begin
      check("res_timeout", 0, 1);
      bus.res_rdy = 1'b0;
      return;
    end
    res_cyc = cyc;
    res_data = bus.res_rdata;
    check("res_val_cycle", cyc, wr ? 57 : 75);
    check("res_rdata", bus.res_rdata, exp_rd);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk); cyc++;
      check("hold_res_val", bus.res_val, 1);
      check("hold_rdata", bus.res_rdata, exp_rd);
      check("hold_req_rdy", bus.req_rdy, 0);
    end
    bus.res_rdy = 1'b1;
    h = cyc;
    idle = ((gap_last > h) ? gap_last : h) + 1;
    @(posedge clk); #1 bus.res_rdy = 1'b0;
    while (cyc < idle) begin
      @(negedge clk); cyc++;
      check("post_res_val", bus.res_val, 0);
      check("req_rdy_return", bus.req_rdy, cyc >= idle);
    end
  endtask

  logic [191:0] wd37;
  logic [7:0]   ids [4];
  logic [15:0]  addrs [4];

  initial begin
    int rc;
    logic [255:0] rd;
    bit after_abort;
    bus.req_val = 1'b0; bus.req_wr = 1'b0; bus.req_id = '0; bus.req_bsel = '0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.res_rdy = 1'b0;
    ref_mem[{8'h25, 16'h0013}] = 256'hDEADBEEF;
    w_mem[{8'h25, 16'h0013}]   = 256'hDEADBEEF;
    wd37 = 192'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978_1357_9BDF_2468_ABCD;
    ids[0] = 8'h25; ids[1] = 8'h26; ids[2] = 8'h3A; ids[3] = 8'h7F;
    addrs[0] = 16'h0013; addrs[1] = 16'h0000; addrs[2] = 16'hFFFF; addrs[3] = 16'h8001;

    #1 rst = 1'b1;
    #2;
    check("reset_req_rdy", bus.req_rdy, 1);
    check("reset_res_val", bus.res_val, 0);
    check("reset_rdata", bus.res_rdata, 0);
    check("reset_bus", {cmd, bdata}, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Preloaded read.
    send(1'b0, 8'h25, 8'h00, 16'h0013, '0, 0, 0, 1'b1, rc, rd);
    check("r38_rdata", rd, 256'hDEADBEEF);
    check("r38_res_cycle", rc, 75);

    // Directed write with hand-derived bus nibbles.
    send(1'b1, 8'h25, 8'h00, 16'h0013, wd37, 0, 0, 1'b0, rc, rd);
    check("w37_c1", trace[1], {C_ID, 4'h2});
    check("w37_c2", trace[2], {C_ID, 4'h5});
    check("w37_c5", trace[5], {C_ADDR, 4'h0});
    check("w37_c6", trace[6], {C_ADDR, 4'h0});
    check("w37_c7", trace[7], {C_ADDR, 4'h1});
    check("w37_c8", trace[8], {C_ADDR, 4'h3});
    check("w37_c53", trace[53], {C_DATA, 4'hA});
    check("w37_c56", trace[56], {C_DATA, 4'hD});
    check("w37_c57", trace[57], 8'h00);
    check("w37_c58", trace[58], 8'h00);
    check("w37_res_cycle", rc, 57);
    check("w37_rdata", rd, 0);

    // Back-to-back read of the written word.
    send(1'b0, 8'h25, 8'h00, 16'h0013, '0, 0, 0, 1'b0, rc, rd);
    check("b2b_rdata", rd, {64'b0, wd37});
    check("b2b_nop_gap", id_gap, PG + 1);

    // Response held off for 20 cycles.
    send(1'b0, 8'h25, 8'h5A, 16'h0013, '0, 20, 0, 1'b0, rc, rd);
    check("hold_rdata_lit", rd, {64'b0, wd37});

    // Reset mid-read, then the same read again.
    send(1'b0, 8'h25, 8'h00, 16'h0013, '0, 0, 30, 1'b0, rc, rd);
    send(1'b0, 8'h25, 8'h00, 16'h0013, '0, 0, 0, 1'b1, rc, rd);
    check("after_rst_rdata", rd, {64'b0, wd37});

    // Unmatched ID.
    send(1'b0, 8'h7F, 8'h00, 16'h0013, '0, 0, 0, 1'b0, rc, rd);
    check("nomatch_rdata", rd, 0);
    check("nomatch_res_cycle", rc, 75);

    after_abort = 1'b0;
    for (int t = 0; t < 40; t++) begin
      bit wr;
      int hold, abort;
      logic [191:0] wd;
      wr = 1'($urandom_range(0, 1));
      wd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0;
      abort = (!wr && $urandom_range(0, 5) == 0) ? int'($urandom_range(1, 74)) : 0;
      send(wr, ids[$urandom_range(0, 3)], 8'($urandom), addrs[$urandom_range(0, 3)],
           wd, hold, abort, after_abort, rc, rd);
      after_abort = (abort != 0);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_total);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/rtap_bist_master.md
RTAP_BIST_MASTER -- requirements
Module: rtap_bist_master

Interface
REQ-001 Parameter POST_GAP, default 2, sets the number of idle-command cycles after each transaction; legal range is 2 to 15.
REQ-002 clk  in  1  sole clock; all flops update on its rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 req_val  in  1  a transaction request is present.
REQ-005 req_rdy  out  1  the block accepts a request on a clock edge where req_val and req_rdy are both 1.
REQ-006 req_wr  in  1  1 = write, 0 = read.
REQ-007 req_id  in  8  target SRAM ID.
REQ-008 req_bsel  in  8  bit-select field.
REQ-009 req_addr  in  16  SRAM address.
REQ-010 req_wdata  in  `JTAG_DATA_REQ_WIDTH (192)  write data.
REQ-011 res_val  out  1  response valid.
REQ-012 res_rdy  in  1  response consumed on a clock edge where res_val and res_rdy are both 1.
REQ-013 res_rdata  out  `JTAG_DATA_RES_WIDTH (256)  read data; zero for writes.
REQ-014 rtap_srams_bist_command  out  `BIST_OP_WIDTH  BIST opcode to the SRAM wrappers.
REQ-015 rtap_srams_bist_data  out  `SRAM_WRAPPER_BUS_WIDTH (4)  nibble to the SRAM wrappers.
REQ-016 srams_rtap_data  in  `SRAM_WRAPPER_BUS_WIDTH (4)  OR-combined nibble returned by all wrappers.

Function
REQ-017 rtap_srams_bist_command and rtap_srams_bist_data SHALL be driven directly from flops.
REQ-018 The NOP command SHALL be all-zero opcode with all-zero data.
REQ-019 The FSM SHALL use these states: IDLE, ID, BSEL, ADDR, OP, RWAIT, RDATA, WDATA, GAP, RESP.
REQ-020 req_rdy SHALL be 1 only in IDLE.
REQ-021 Cycle numbering: the acceptance edge is E0, and bus cycle n is the cycle after edge E(n-1).
REQ-022 Every transaction SHALL drive the following on cycles 1 to 8:
- Cycles 1-2: SHIFT_ID with req_id[7:4], then req_id[3:0].
- Cycles 3-4: SHIFT_BSEL with bsel[7:4], then bsel[3:0].
- Cycles 5-8: SHIFT_ADDRESS with addr[15:12], [11:8], [7:4], [3:0].
REQ-023 On a read, the block SHALL drive:
- Cycle 9: BIST_OP_READ with data 0.
- Cycle 10: NOP (RWAIT).
- Cycles 11-74: SHIFT_DATA with data 0 (RDATA, 64 cycles).
REQ-024 During RDATA, srams_rtap_data SHALL be sampled at the end of each cycle and shifted in MSB-first, so the cycle-11 sample lands in res_rdata[255:252] and the cycle-74 sample lands in [3:0].
REQ-025 On a write, cycles 9-56 SHALL drive SHIFT_DATA carrying req_wdata[191:188] first and [3:0] last (48 nibbles; OP plus WDATA).
REQ-026 After the final data cycle, the block SHALL drive NOP for exactly POST_GAP cycles (GAP), covering the wrapper's write-commit and idle cycles.
REQ-027 res_val SHALL rise on the first GAP cycle.
REQ-028 res_val and res_rdata SHALL be held stable until consumed.
REQ-029 The block SHALL return to IDLE only when GAP has elapsed and the response has been consumed; RESP waits for res_rdy if GAP ends first.
REQ-030 A request and response handshake on the same edge SHALL be impossible, since req_rdy is 0 while res_val is 1.
REQ-031 A single 7-bit counter SHALL sequence the nibbles within each state; it resets to 0 on every state change.
REQ-032 An ID with no matching wrapper SHALL complete normally; res_rdata is then whatever srams_rtap_data carried (all-zero from idle wrappers).
REQ-033 req_* inputs SHALL be captured at E0; changes to them after E0 SHALL have no effect.

Reset
REQ-034 Asserting rst SHALL immediately force:
- state = IDLE
- req_rdy = 1
- res_val = 0
- res_rdata = 0
- command and data = NOP
- counter = 0
REQ-035 Asserting rst mid-transaction SHALL abort it with no response; the NOP output returns any wrapper to its idle state within one cycle.
REQ-036 The first request SHALL be accepted on the first edge after rst deasserts.

Verification
REQ-037 Write id=0x25, bsel=0x00, addr=0x0013, wdata=0x…ABCD: the bus must show:
- cycle 1: SHIFT_ID/2
- cycle 2: SHIFT_ID/5
- cycles 5-8: addr nibbles 0,0,1,3
- cycle 53: SHIFT_DATA/A
- cycle 56: SHIFT_DATA/D
- cycles 57-58: NOP
- cycle 57: res_val = 1
REQ-038 Read against a wrapper model for ID 0x25 pre-loaded with 0xDEADBEEF at 0x0013 -> res_rdata = 0x…DEADBEEF, with res_val on cycle 75.
REQ-039 Back-to-back: write then read of the same address with res_rdy tied to 1 -> the read returns the written data and the second SHIFT_ID appears POST_GAP+1 cycles after the last SHIFT_DATA.
REQ-040 res_rdy held at 0 for 20 cycles after res_val -> res_val and res_rdata stay stable, req_rdy stays 0, and req_rdy rises one cycle after the res_rdy handshake.
REQ-041 rst pulsed at cycle 30 of a read -> outputs are NOP within the same cycle, and a following read of the same wrapper returns correct data.
REQ-042 Read with id=0x7F and no matching wrapper -> res_rdata = 0 and the full 74-cycle sequence completes.
